// File: rtl/irq_source_arbiter.sv
// irq_source_arbiter: latches interrupt lines, masks them and requests the lowest-index winner from the core controller; IRQ_ARB_LEVEL_EN selects level-sensitive sources.
module irq_source_arbiter #(
    parameter int          N_SRC      = 8,
    parameter logic [31:0] CAUSE_BASE = 32'h80000010
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_SRC-1:0]         irq_lines_i,
    input  logic [N_SRC-1:0]         irq_mask_i,
    input  logic                     irq_ack_i,
    input  logic                     irq_ret_i,
    output logic                     irq_o,
    output logic [31:0]              irq_cause_o,
    output logic [$clog2(N_SRC)-1:0] irq_id_o,
    output logic                     irq_busy_o
);
    localparam int IW = $clog2(N_SRC);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] id_q, id_d, win;
    logic [N_SRC-1:0] pend, cand;
`ifdef IRQ_ARB_LEVEL_EN
    assign pend = irq_lines_i;
`else
    logic [N_SRC-1:0] line_q, pend_q, pend_d;
    always_comb begin
        pend_d = pend_q;
        if (state_q == REQ && irq_ack_i) pend_d[id_q] = 1'b0;
        // a new edge in the ack cycle must survive the clear
        pend_d = pend_d | (irq_lines_i & ~line_q);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            line_q <= '0;
            pend_q <= '0;
        end else begin
            line_q <= irq_lines_i;
            pend_q <= pend_d;
        end
    end
    assign pend = pend_q;
`endif
    assign cand = pend & irq_mask_i;
    always_comb begin
        win = '0;
        for (int k = N_SRC - 1; k >= 0; k--) if (cand[k]) win = IW'(k);
    end
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: if (|cand) begin
                id_d    = win;
                state_d = REQ;
            end
            // the request is withdrawn once its source stops being a candidate
            REQ: state_d = irq_ack_i ? SERVICE : (!cand[id_q] ? IDLE : REQ);
            SERVICE: state_d = irq_ret_i ? IDLE : SERVICE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end
    assign irq_o       = (state_q == REQ);
    assign irq_busy_o  = (state_q == SERVICE);
    assign irq_id_o    = id_q;
    assign irq_cause_o = CAUSE_BASE + 32'(id_q);
endmodule

// File: tb/tb_irq_source_arbiter.sv
// tb_irq_source_arbiter: directed and random stimulus scored against a cycle model of the arbiter.
module tb_irq_source_arbiter;
    localparam logic [31:0] CB = 32'h80000010;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [7:0] irq_lines_i = '0;
    logic [7:0] irq_mask_i = 8'hFF;
    logic irq_ack_i = 1'b0;
    logic irq_ret_i = 1'b0;
    logic irq_o, irq_busy_o;
    logic [31:0] irq_cause_o;
    logic [2:0] irq_id_o;
    int n_checks = 0;
    int n_fail = 0;
    logic [36:0] exp_q[$];
    int m_st;
    int m_id;
    bit [7:0] m_pend;
    bit [7:0] m_prev;

    irq_source_arbiter #(.N_SRC(8), .CAUSE_BASE(CB)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .irq_lines_i(irq_lines_i), .irq_mask_i(irq_mask_i),
        .irq_ack_i(irq_ack_i), .irq_ret_i(irq_ret_i), .irq_o(irq_o), .irq_cause_o(irq_cause_o),
        .irq_id_o(irq_id_o), .irq_busy_o(irq_busy_o)
    );

    always #5 clk = ~clk;

    task automatic model(input bit r, input bit [7:0] l, input bit [7:0] m, input bit a, input bit t);
        bit [7:0] c;
        bit [7:0] np;
        int w;
        if (!r) begin
            m_st = 0; m_id = 0; m_pend = '0; m_prev = '0;
        end else begin
            c = m_pend & m;
            w = -1;
            for (int k = 7; k >= 0; k--) if (c[k]) w = k;
            np = m_pend;
            if (m_st == 1 && a) np[m_id] = 1'b0;
            np = np | (l & ~m_prev);
            if (m_st == 0 && w >= 0) begin
                m_id = w; m_st = 1;
            end else if (m_st == 1 && a) m_st = 2;
            else if (m_st == 1 && !m[m_id]) m_st = 0;
            else if (m_st == 2 && t) m_st = 0;
            m_pend = np; m_prev = l;
        end
        exp_q.push_back({m_st == 1, m_st == 2, 3'(m_id), CB + 32'(m_id)});
    endtask

    task automatic cyc(input bit r, input bit [7:0] l, input bit [7:0] m, input bit a, input bit t);
        @(negedge clk);
        rst_ni = r; irq_lines_i = l; irq_mask_i = m; irq_ack_i = a; irq_ret_i = t;
        model(r, l, m, a, t);
    endtask

    task automatic chk(input string name, input bit e_irq, input bit e_busy, input bit [2:0] e_id);
        logic [36:0] got, want;
        @(posedge clk); #1;
        got  = {irq_o, irq_busy_o, irq_id_o, irq_cause_o};
        want = {e_irq, e_busy, e_id, CB + 32'(e_id)};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got irq=%b busy=%b id=%0d cause=%h, want irq=%b busy=%b id=%0d cause=%h",
                     name, got[36], got[35], got[34:32], got[31:0], want[36], want[35], want[34:32], want[31:0]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() > 0) begin
                logic [36:0] e;
                logic [36:0] g;
                e = exp_q.pop_front();
                g = {irq_o, irq_busy_o, irq_id_o, irq_cause_o};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got irq=%b busy=%b id=%0d cause=%h, want irq=%b busy=%b id=%0d cause=%h",
                             $time, g[36], g[35], g[34:32], g[31:0], e[36], e[35], e[34:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        bit got4;
        cyc(0, 0, 8'hFF, 0, 0);
        cyc(0, 0, 8'hFF, 0, 0);
        chk("reset", 0, 0, 0);
        cyc(1, 8'h08, 8'hFF, 0, 0);
        cyc(1, 0, 8'hFF, 0, 0);
        chk("single_req", 1, 0, 3);
        cyc(1, 0, 8'hFF, 1, 0);
        chk("single_ack", 0, 1, 3);
        cyc(1, 0, 8'hFF, 0, 1);
        chk("single_ret", 0, 0, 3);
        cyc(1, 8'h24, 8'hFF, 0, 0);
        cyc(1, 0, 8'hFF, 0, 0);
        chk("prio_first", 1, 0, 2);
        cyc(1, 0, 8'hFF, 1, 0);
        cyc(1, 0, 8'hFF, 0, 1);
        chk("prio_idle_gap", 0, 0, 2);
        cyc(1, 0, 8'hFF, 0, 0);
        chk("prio_second", 1, 0, 5);
        cyc(1, 0, 8'hFF, 1, 0);
        cyc(1, 0, 8'hFF, 0, 1);
        cyc(1, 8'h10, 8'hEF, 0, 0);
        cyc(1, 0, 8'hEF, 0, 0);
        cyc(1, 0, 8'hEF, 0, 0);
        chk("masked_quiet", 0, 0, 5);
        got4 = 0;
        for (int i = 0; i < 3 && !got4; i++) begin
            cyc(1, 0, 8'hFF, 0, 0);
            @(posedge clk); #1;
            got4 = irq_o && irq_id_o == 3'd4;
        end
        n_checks++;
        if (!got4) begin
            n_fail++;
            $display("FAIL unmask_req: got irq=%b id=%0d, want irq=1 id=4 within 3 cycles", irq_o, irq_id_o);
        end
        cyc(1, 0, 8'hFF, 1, 0);
        cyc(1, 0, 8'hFF, 0, 1);
        cyc(1, 8'h40, 8'hFF, 0, 0);
        cyc(1, 0, 8'hFF, 0, 0);
        chk("mdrop_req", 1, 0, 6);
        cyc(1, 0, 8'hBF, 0, 0);
        chk("mdrop_idle", 0, 0, 6);
        cyc(1, 0, 8'hBF, 0, 0);
        cyc(1, 0, 8'hFF, 0, 0);
        chk("mdrop_rereq", 1, 0, 6);
        cyc(1, 0, 8'hFF, 1, 0);
        cyc(1, 0, 8'hFF, 0, 1);
        cyc(1, 8'h02, 8'hFF, 0, 0);
        cyc(1, 0, 8'hFF, 0, 0);
        chk("rearr_req", 1, 0, 1);
        cyc(1, 8'h02, 8'hFF, 1, 0);
        chk("rearr_svc", 0, 1, 1);
        cyc(1, 0, 8'hFF, 0, 1);
        cyc(1, 0, 8'hFF, 0, 0);
        chk("rearr_again", 1, 0, 1);
        cyc(1, 0, 8'hFF, 1, 0);
        cyc(1, 0, 8'hFF, 0, 1);
        cyc(1, 8'h81, 8'hFF, 0, 0);
        cyc(1, 0, 8'hFF, 0, 0);
        cyc(1, 0, 8'hFF, 1, 0);
        chk("rst_busy", 0, 1, 0);
        cyc(0, 0, 8'hFF, 0, 0);
        chk("rst_mid", 0, 0, 0);
        cyc(1, 0, 8'hFF, 0, 0);
        cyc(1, 0, 8'hFF, 0, 0);
        chk("rst_cleared", 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit [7:0] l;
            bit [7:0] m;
            l = 8'($urandom) & 8'($urandom) & 8'($urandom);
            m = 8'($urandom) | 8'($urandom);
            cyc($urandom_range(0, 99) != 0, l, m, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
